// File: rtl/arb_rr4.sv
// Four-way round-robin arbiter with a bounded hold time and a one-cycle turnaround gap between owners.
// Grant appears one cycle after the request is sampled; requesters see no backpressure and simply hold R until granted.
module arb_rr4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] R,
  input  logic       Done,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic [1:0] W,
  output logic       En,
  output logic       Timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] w_q, w_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic       to_q, to_d;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic       hold_hit;
  logic       release_req;

  // First set request bit scanning upward from the rotating pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!pick_vld && R[ptr_q + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 2'(k);
      end
    end
  end

  assign hold_hit    = (cnt_q == CNT_LAST);
  assign release_req = Done | ~R[w_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    to_d    = 1'b0;

    case (state_q)
      S_BUSY: begin
        if (release_req || hold_hit) begin
          state_d = S_GAP;
          grant_d = 4'b0000;
          cnt_d   = 4'd0;
          ptr_d   = w_q + 2'd1;
          // A voluntary release on the limit cycle wins over the revoke.
          to_d    = hold_hit & ~release_req;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        grant_d = 4'b0000;
        cnt_d   = 4'd0;
        if (pick_vld) begin
          state_d = S_BUSY;
          w_d     = pick_idx;
          grant_d = 4'b0001 << pick_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      w_q     <= 2'd0;
      cnt_q   <= 4'd0;
      grant_q <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      to_q    <= to_d;
    end
  end

  assign {y3, y2, y1, y0} = grant_q;
  assign W                = w_q;
  assign En               = |grant_q;
  assign Timeout          = to_q;

endmodule
